// File: rtl/mc_cu.sv
// mc_cu: multi-cycle control unit for the multi-cycle CPU datapath.
// Sequences each instruction through IF, ID, EX, MEM and WB. IF and MEM wait
// on mem_ready. Strobes are decoded from the registered state and the
// instruction class captured at ID->EX. retire marks each completed
// instruction.
//
// Optional feature macro: MC_CU_TRAP_EN. When defined, an illegal instruction
// parks the unit in TRAP until reset. When undefined, it retires as a NOP.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode, funct       Inst[31:26] and Inst[5:0] from the instruction register
//   zf, sf              ALU zero / sign flags, used in EX for branches
//   mem_ready           memory completed the current access this cycle
//   pc_wr, ir_wr        PC load, instruction register load
//   pc_src              00 PC+4, 01 branch target, 10 jump target
//   alu_src_a/b         0 Rs / 1 shamt ; 0 Rt / 1 extended immediate
//   ext_sel             0 zero-extend, 1 sign-extend
//   reg_dst, data_src   0 Rt / 1 Rd ; 0 ALU result / 1 memory data
//   reg_wr, mem_rd, mem_wr  register write, memory read, memory write
//   alu_ctrl            ALU operation, zero-extended to ALU_CTRL_W
//   state               IF=0 ID=1 EX=2 MEM=3 WB=4 TRAP=7
//   retire, illegal     one-cycle completion and illegal-instruction pulses
module mc_cu #(
    parameter int unsigned ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zf,
    input  logic                  sf,
    input  logic                  mem_ready,
    output logic                  pc_wr,
    output logic                  ir_wr,
    output logic [1:0]            pc_src,
    output logic                  alu_src_a,
    output logic                  alu_src_b,
    output logic                  ext_sel,
    output logic                  reg_dst,
    output logic                  data_src,
    output logic                  reg_wr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [2:0]            state,
    output logic                  retire,
    output logic                  illegal
);

    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [CODE_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [CODE_W-1:0] ALU_SLL  = 4'b0010;
    localparam logic [CODE_W-1:0] ALU_NOR  = 4'b0011;
    localparam logic [CODE_W-1:0] ALU_ADD  = 4'b0100;
    localparam logic [CODE_W-1:0] ALU_ADDU = 4'b0101;
    localparam logic [CODE_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [CODE_W-1:0] ALU_SRL  = 4'b0111;
    localparam logic [CODE_W-1:0] ALU_SLTU = 4'b1000;
    localparam logic [CODE_W-1:0] ALU_SLT  = 4'b1001;
    localparam logic [CODE_W-1:0] ALU_XOR  = 4'b1010;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_ALUI = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BR   = 3'd4
    } cls_t;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LTZ = 3'd2,
        BR_GTZ = 3'd3,
        BR_LEZ = 3'd4
    } br_t;

    state_t            cur, nxt;

    logic              dec_ok, dec_j, dec_sa, dec_sb, dec_ext;
    cls_t              dec_cls;
    br_t               dec_br;
    logic [CODE_W-1:0] dec_alu;

    cls_t              d_cls;
    br_t               d_br;
    logic [CODE_W-1:0] d_alu;
    logic              d_sa, d_sb, d_ext;
    logic              taken;

    // Live decode of the instruction register, only consumed in ID.
    always_comb begin
        dec_ok  = 1'b1;
        dec_j   = 1'b0;
        dec_cls = CLS_ALUI;
        dec_br  = BR_EQ;
        dec_alu = ALU_ADD;
        dec_sa  = 1'b0;
        dec_sb  = 1'b1;
        dec_ext = 1'b1;
        case (opcode)
            6'h00: begin
                dec_cls = CLS_R;
                dec_sb  = 1'b0;
                case (funct)
                    6'h20: dec_alu = ALU_ADD;
                    6'h21: dec_alu = ALU_ADDU;
                    6'h22: dec_alu = ALU_SUB;
                    6'h24: dec_alu = ALU_AND;
                    6'h25: dec_alu = ALU_OR;
                    6'h26: dec_alu = ALU_XOR;
                    6'h27: dec_alu = ALU_NOR;
                    6'h2A: dec_alu = ALU_SLT;
                    6'h2B: dec_alu = ALU_SLTU;
                    6'h00: begin dec_alu = ALU_SLL; dec_sa = 1'b1; end
                    6'h02: begin dec_alu = ALU_SRL; dec_sa = 1'b1; end
                    6'h04: dec_alu = ALU_SLL;
                    6'h06: dec_alu = ALU_SRL;
                    default: dec_ok = 1'b0;
                endcase
            end
            6'h08: dec_alu = ALU_ADD;
            6'h09: dec_alu = ALU_ADDU;
            6'h0A: dec_alu = ALU_SLT;
            6'h0B: dec_alu = ALU_SLTU;
            6'h0C: begin dec_alu = ALU_AND; dec_ext = 1'b0; end
            6'h0D: begin dec_alu = ALU_OR;  dec_ext = 1'b0; end
            6'h0E: dec_alu = ALU_XOR;
            6'h23: dec_cls = CLS_LW;
            6'h2B: dec_cls = CLS_SW;
            6'h04: begin dec_cls = CLS_BR; dec_br = BR_EQ;  dec_alu = ALU_SUB; dec_sb = 1'b0; end
            6'h05: begin dec_cls = CLS_BR; dec_br = BR_NE;  dec_alu = ALU_SUB; dec_sb = 1'b0; end
            6'h01: begin dec_cls = CLS_BR; dec_br = BR_LTZ; dec_sb = 1'b0; end
            6'h07: begin dec_cls = CLS_BR; dec_br = BR_GTZ; dec_sb = 1'b0; end
            6'h06: begin dec_cls = CLS_BR; dec_br = BR_LEZ; dec_sb = 1'b0; end
            6'h02: dec_j = 1'b1;
            default: dec_ok = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_IF;
        else        cur <= nxt;
    end

    // Decode capture at ID->EX; EX/MEM/WB never look at the live opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_cls <= CLS_R;
            d_br  <= BR_EQ;
            d_alu <= '0;
            d_sa  <= 1'b0;
            d_sb  <= 1'b0;
            d_ext <= 1'b0;
        end else if (cur == S_ID && nxt == S_EX) begin
            d_cls <= dec_cls;
            d_br  <= dec_br;
            d_alu <= dec_alu;
            d_sa  <= dec_sa;
            d_sb  <= dec_sb;
            d_ext <= dec_ext;
        end
    end

    // Branch condition from the EX flags.
    always_comb begin
        taken = 1'b0;
        case (d_br)
            BR_EQ:   taken = zf;
            BR_NE:   taken = !zf;
            BR_LTZ:  taken = sf;
            BR_GTZ:  taken = !sf && !zf;
            BR_LEZ:  taken = sf || zf;
            default: taken = 1'b0;
        endcase
    end

    // Next state and state-decoded strobes.
    always_comb begin
        nxt       = cur;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        pc_src    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        reg_dst   = 1'b0;
        data_src  = 1'b0;
        reg_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        alu_ctrl  = '0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (cur)
            S_IF: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                    nxt   = S_ID;
                end
            end
            S_ID: begin
                if (!dec_ok) begin
                    illegal = 1'b1;
`ifdef MC_CU_TRAP_EN
                    nxt     = S_TRAP;
`else
                    retire  = 1'b1;
                    nxt     = S_IF;
`endif
                end else if (dec_j) begin
                    pc_wr  = 1'b1;
                    pc_src = 2'b10;
                    retire = 1'b1;
                    nxt    = S_IF;
                end else begin
                    nxt = S_EX;
                end
            end
            S_EX: begin
                alu_ctrl  = ALU_CTRL_W'(d_alu);
                alu_src_a = d_sa;
                alu_src_b = d_sb;
                ext_sel   = d_ext;
                case (d_cls)
                    CLS_R, CLS_ALUI: nxt = S_WB;
                    CLS_LW, CLS_SW:  nxt = S_MEM;
                    default: begin
                        if (taken) begin
                            pc_wr  = 1'b1;
                            pc_src = 2'b01;
                        end
                        retire = 1'b1;
                        nxt    = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                if (d_cls == CLS_LW) mem_rd = 1'b1;
                else                 mem_wr = 1'b1;
                if (mem_ready) begin
                    if (d_cls == CLS_LW) begin
                        nxt = S_WB;
                    end else begin
                        retire = 1'b1;
                        nxt    = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_wr   = 1'b1;
                retire   = 1'b1;
                reg_dst  = (d_cls == CLS_R);
                data_src = (d_cls == CLS_LW);
                nxt      = S_IF;
            end
`ifdef MC_CU_TRAP_EN
            S_TRAP: nxt = S_TRAP;
`endif
            default: nxt = S_IF;
        endcase
        // Reset silences every strobe at once, including mem_rd in IF.
        if (!rst_n) begin
            pc_wr     = 1'b0;
            ir_wr     = 1'b0;
            pc_src    = 2'b00;
            alu_src_a = 1'b0;
            alu_src_b = 1'b0;
            ext_sel   = 1'b0;
            reg_dst   = 1'b0;
            data_src  = 1'b0;
            reg_wr    = 1'b0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            alu_ctrl  = '0;
            retire    = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mc_cu.sv
// Self-checking bench for mc_cu: directed scenarios plus random instruction
// streams compared cycle by cycle against an instruction-level trace model.
module tb_mc_cu;

    logic       clk, rst_n;
    logic [5:0] opcode, funct;
    logic       zf, sf, mem_ready;
    logic       pc_wr, ir_wr;
    logic [1:0] pc_src;
    logic       alu_src_a, alu_src_b, ext_sel, reg_dst, data_src;
    logic       reg_wr, mem_rd, mem_wr;
    logic [3:0] alu_ctrl;
    logic [2:0] state;
    logic       retire, illegal;

    mc_cu #(.ALU_CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zf(zf), .sf(sf), .mem_ready(mem_ready),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sel(ext_sel),
        .reg_dst(reg_dst), .data_src(data_src), .reg_wr(reg_wr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_ctrl(alu_ctrl),
        .state(state), .retire(retire), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_wr, ir_wr;
        logic [1:0] pc_src;
        logic       sa, sb, ext, rdst, dsrc, rwr, mrd, mwr;
        logic [3:0] alu;
        logic [2:0] st;
        logic       ret, ill;
    } ov_t;

    typedef struct packed {
        logic       ok, j;
        logic [2:0] kind;
        logic [3:0] alu;
        logic       sa, sb, ext;
    } info_t;

    localparam logic [2:0] K_R = 3'd0, K_ALUI = 3'd1, K_LW = 3'd2, K_SW = 3'd3, K_BR = 3'd4;

    ov_t obs;
    assign obs = {pc_wr, ir_wr, pc_src, alu_src_a, alu_src_b, ext_sel, reg_dst,
                  data_src, reg_wr, mem_rd, mem_wr, alu_ctrl, state, retire, illegal};

    int total = 0;
    int bad   = 0;

    ov_t        exp_q[$];
    logic [2:0] in_q[$];   // {mem_ready, zf, sf} per cycle

    logic [5:0] r_fn [13] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00,
                              6'h02, 6'h04, 6'h06, 6'h2A, 6'h2B, 6'h26};
    logic [5:0] i_op [15] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23,
                              6'h2B, 6'h04, 6'h05, 6'h01, 6'h07, 6'h06, 6'h02};

    function automatic logic rbit();
        return 1'($urandom & 32'd1);
    endfunction

    // Instruction semantics table: class, ALU op and operand selects.
    function automatic info_t ref_info(input logic [5:0] op, input logic [5:0] fn);
        info_t r;
        r = '0; r.ok = 1'b1; r.sb = 1'b1; r.ext = 1'b1; r.kind = K_ALUI; r.alu = 4'b0100;
        case (op)
            6'h00: begin
                r.kind = K_R; r.sb = 1'b0;
                case (fn)
                    6'h20: r.alu = 4'b0100;  6'h21: r.alu = 4'b0101;
                    6'h22: r.alu = 4'b0110;  6'h24: r.alu = 4'b0000;
                    6'h25: r.alu = 4'b0001;  6'h27: r.alu = 4'b0011;
                    6'h26: r.alu = 4'b1010;  6'h2A: r.alu = 4'b1001;
                    6'h2B: r.alu = 4'b1000;
                    6'h00: begin r.alu = 4'b0010; r.sa = 1'b1; end
                    6'h02: begin r.alu = 4'b0111; r.sa = 1'b1; end
                    6'h04: r.alu = 4'b0010;  6'h06: r.alu = 4'b0111;
                    default: r.ok = 1'b0;
                endcase
            end
            6'h08: r.alu = 4'b0100;  6'h09: r.alu = 4'b0101;
            6'h0A: r.alu = 4'b1001;  6'h0B: r.alu = 4'b1000;
            6'h0C: begin r.alu = 4'b0000; r.ext = 1'b0; end
            6'h0D: begin r.alu = 4'b0001; r.ext = 1'b0; end
            6'h0E: r.alu = 4'b1010;
            6'h23: r.kind = K_LW;
            6'h2B: r.kind = K_SW;
            6'h04, 6'h05: begin r.kind = K_BR; r.alu = 4'b0110; r.sb = 1'b0; end
            6'h01, 6'h07, 6'h06: begin r.kind = K_BR; r.sb = 1'b0; end
            6'h02: r.j = 1'b1;
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic br_taken(input logic [5:0] op, input logic z, input logic s);
        case (op)
            6'h04:   return z;
            6'h05:   return !z;
            6'h01:   return s;
            6'h07:   return !s && !z;
            default: return s || z;
        endcase
    endfunction

    // Expected per-cycle outputs and inputs for one whole instruction.
    task automatic build_trace(input logic [5:0] op, input logic [5:0] fn,
                               input int wif, input int wmem, input logic z, input logic s);
        info_t inf;
        ov_t   e;
        inf = ref_info(op, fn);
        exp_q.delete(); in_q.delete();
        for (int i = 0; i <= wif; i++) begin
            e = '0; e.mrd = 1'b1;
            if (i == wif) begin e.ir_wr = 1'b1; e.pc_wr = 1'b1; end
            exp_q.push_back(e); in_q.push_back({(i == wif), rbit(), rbit()});
        end
        e = '0; e.st = 3'd1;
        if (!inf.ok) begin
            e.ill = 1'b1;
`ifndef MC_CU_TRAP_EN
            e.ret = 1'b1;
`endif
            exp_q.push_back(e); in_q.push_back({rbit(), rbit(), rbit()});
            return;
        end
        if (inf.j) begin
            e.pc_wr = 1'b1; e.pc_src = 2'b10; e.ret = 1'b1;
            exp_q.push_back(e); in_q.push_back({rbit(), rbit(), rbit()});
            return;
        end
        exp_q.push_back(e); in_q.push_back({rbit(), rbit(), rbit()});
        e = '0; e.st = 3'd2; e.alu = inf.alu; e.sa = inf.sa; e.sb = inf.sb; e.ext = inf.ext;
        if (inf.kind == K_BR) begin
            if (br_taken(op, z, s)) begin e.pc_wr = 1'b1; e.pc_src = 2'b01; end
            e.ret = 1'b1;
        end
        exp_q.push_back(e); in_q.push_back({rbit(), z, s});
        if (inf.kind == K_BR) return;
        if (inf.kind == K_LW || inf.kind == K_SW) begin
            for (int i = 0; i <= wmem; i++) begin
                e = '0; e.st = 3'd3;
                e.mrd = (inf.kind == K_LW); e.mwr = (inf.kind == K_SW);
                if (i == wmem && inf.kind == K_SW) e.ret = 1'b1;
                exp_q.push_back(e); in_q.push_back({(i == wmem), rbit(), rbit()});
            end
            if (inf.kind == K_SW) return;
        end
        e = '0; e.st = 3'd4; e.rwr = 1'b1; e.ret = 1'b1;
        e.rdst = (inf.kind == K_R); e.dsrc = (inf.kind == K_LW);
        exp_q.push_back(e); in_q.push_back({rbit(), rbit(), rbit()});
    endtask

    task automatic drive_cycle(input logic [2:0] v);
        @(negedge clk);
        mem_ready = v[2]; zf = v[1]; sf = v[0];
        #1;
    endtask

    task automatic test_reset;
        ov_t e;
        e = '0;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h23; funct = 6'h00; zf = 1'b0; sf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL reset cyc%0d: got %h want %h", i, obs, e);
            end
        end
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
        total++;
        if (mem_rd !== 1'b1 || state !== 3'd0) begin
            bad++; $display("FAIL reset_release: mem_rd=%b state=%0d want 1/0", mem_rd, state);
        end
    endtask

    task automatic test_add;
        build_trace(6'h00, 6'h20, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            drive_cycle(in_q[i]);
            if (i == 0) begin opcode = 6'h00; funct = 6'h20; end
            total++;
            if (obs !== exp_q[i]) begin
                bad++; $display("FAIL add cyc%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
        drive_cycle(3'b000);
        total++;
        if (state !== 3'd0 || mem_rd !== 1'b1 || retire !== 1'b0) begin
            bad++; $display("FAIL add_after: state=%0d mem_rd=%b retire=%b want 0/1/0", state, mem_rd, retire);
        end
    endtask

    task automatic test_lw_wait;
        build_trace(6'h23, 6'h15, 0, 2, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            drive_cycle(in_q[i]);
            if (i == 0) begin opcode = 6'h23; funct = 6'h15; end
            total++;
            if (obs !== exp_q[i]) begin
                bad++; $display("FAIL lw_wait cyc%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
        drive_cycle(3'b000);
        total++;
        if (state !== 3'd0 || reg_wr !== 1'b0) begin
            bad++; $display("FAIL lw_after: state=%0d reg_wr=%b want 0/0", state, reg_wr);
        end
    endtask

    task automatic test_beq;
        for (int k = 0; k < 2; k++) begin
            build_trace(6'h04, 6'h00, 0, 0, (k == 0), 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                drive_cycle(in_q[i]);
                if (i == 0) begin opcode = 6'h04; funct = 6'h00; end
                total++;
                if (obs !== exp_q[i]) begin
                    bad++; $display("FAIL beq%0d cyc%0d: got %h want %h", k, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_illegal;
        ov_t e;
        build_trace(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            drive_cycle(in_q[i]);
            if (i == 0) begin opcode = 6'h3F; funct = 6'h00; end
            total++;
            if (obs !== exp_q[i]) begin
                bad++; $display("FAIL illegal cyc%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
`ifdef MC_CU_TRAP_EN
        e = '0; e.st = 3'd7;
        for (int i = 0; i < 20; i++) begin
            drive_cycle({rbit(), rbit(), rbit()});
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL trap_hold cyc%0d: got %h want %h", i, obs, e);
            end
        end
`else
        e = '0; e.mrd = 1'b1;
        drive_cycle(3'b000);
        total++;
        if (obs !== e) begin
            bad++; $display("FAIL illegal_after: got %h want %h", obs, e);
        end
`endif
    endtask

    task automatic test_reset_mid_sw;
        @(negedge clk); rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        opcode = 6'h2B; funct = 6'h09;
        drive_cycle(3'b100);
        drive_cycle({rbit(), 2'b00});
        drive_cycle({rbit(), 2'b00});
        drive_cycle(3'b000);
        total++;
        if (mem_wr !== 1'b1 || state !== 3'd3) begin
            bad++; $display("FAIL sw_mem: mem_wr=%b state=%0d want 1/3", mem_wr, state);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_wr !== 1'b0 || state !== 3'd0 || retire !== 1'b0) begin
            bad++; $display("FAIL sw_abort: mem_wr=%b state=%0d retire=%b want 0/0/0", mem_wr, state, retire);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(3'b100);
            total++;
            if (retire !== 1'b0 || mem_wr !== 1'b0 || reg_wr !== 1'b0 || mem_rd !== 1'b0) begin
                bad++; $display("FAIL sw_in_reset cyc%0d: retire=%b mem_wr=%b reg_wr=%b mem_rd=%b want 0", i, retire, mem_wr, reg_wr, mem_rd);
            end
        end
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
        total++;
        if (state !== 3'd0 || retire !== 1'b0 || mem_wr !== 1'b0 || mem_rd !== 1'b1) begin
            bad++; $display("FAIL sw_release: state=%0d retire=%b mem_wr=%b mem_rd=%b want 0/0/0/1", state, retire, mem_wr, mem_rd);
        end
    endtask

    task automatic test_random(input int n);
        logic [5:0] op, fn;
        int         sel;
        for (int k = 0; k < n; k++) begin
            sel = int'($urandom_range(0, 99));
            fn  = 6'($urandom);
            if (sel < 40) begin
                op = 6'h00; fn = r_fn[$urandom_range(0, 12)];
            end else begin
                op = i_op[$urandom_range(0, 14)];
            end
`ifndef MC_CU_TRAP_EN
            if (sel >= 90) begin op = 6'($urandom); fn = 6'($urandom); end
`endif
            build_trace(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rbit(), rbit());
            for (int i = 0; i < exp_q.size(); i++) begin
                drive_cycle(in_q[i]);
                if (i == 0) begin opcode = op; funct = fn; end
                total++;
                if (obs !== exp_q[i]) begin
                    bad++; $display("FAIL rand k=%0d op=%h fn=%h cyc%0d: got %h want %h", k, op, fn, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_reset_mid_sw();
        test_random(150);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
